// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and helpers for the iterative divider.
package div_unit_pkg;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_func_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  function automatic logic fn_signed(div_func_t f);
    return ~f[0];
  endfunction
  function automatic logic fn_rem(div_func_t f);
    return f[1];
  endfunction
endpackage

// File: rtl/div_if.sv
// div_if: execute-stage request/response handshake to the divide unit.
interface div_if #(parameter int WIDTH = 32);
  import div_unit_pkg::*;
  logic             req_valid;
  logic             req_ready;
  div_func_t        req_fn;
  logic [WIDTH-1:0] req_in1;
  logic [WIDTH-1:0] req_in2;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_out;
  modport master (
    output req_valid, req_fn, req_in1, req_in2, resp_ready,
    input  req_ready, resp_valid, resp_out
  );
  modport slave (
    input  req_valid, req_fn, req_in1, req_in2, resp_ready,
    output req_ready, resp_valid, resp_out
  );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring division iteration on unsigned magnitudes.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ok;
  // The shifted remainder needs one extra bit; any kept difference fits back in WIDTH.
  assign trial   = {rem_in, quo_in[WIDTH-1]};
  assign ok      = trial >= {1'b0, divisor};
  assign diff    = trial[WIDTH-1:0] - divisor;
  assign rem_out = ok ? diff : trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ok};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
module div_unit
  import div_unit_pkg::*;
#(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  rst,
  input logic  flush,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  div_state_t       state, state_n;
  logic [WIDTH-1:0] rem, quo, dvs, res, rem_n, quo_n, mag1, mag2;
  logic [CW-1:0]    cnt;
  logic             qneg, rneg, is_rem, accept, div0, ovf, sgn, last;
  assign sgn    = fn_signed(bus.req_fn);
  assign accept = bus.req_valid && bus.req_ready && !flush;
  assign div0   = bus.req_in2 == '0;
  assign ovf    = sgn && bus.req_in1 == {1'b1, {(WIDTH-1){1'b0}}} && &bus.req_in2;
  assign mag1   = sgn && bus.req_in1[WIDTH-1] ? -bus.req_in1 : bus.req_in1;
  assign mag2   = sgn && bus.req_in2[WIDTH-1] ? -bus.req_in2 : bus.req_in2;
  assign last   = cnt == CW'(1);
  assign bus.resp_out = res;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem),
    .quo_in (quo),
    .divisor(dvs),
    .rem_out(rem_n),
    .quo_out(quo_n)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = flush             ? IDLE :
              state == IDLE     ? (accept ? (div0 || ovf ? DONE : CALC) : IDLE) :
              state == CALC     ? (last ? DONE : CALC) :
              bus.resp_ready    ? IDLE : DONE;
  end
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == DONE;
  end
  // Special cases resolve at accept; normal ops sign-fix on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      res    <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      is_rem <= 1'b0;
    end else if (accept) begin
      rem    <= '0;
      quo    <= mag1;
      dvs    <= mag2;
      cnt    <= CW'(WIDTH);
      qneg   <= sgn && (bus.req_in1[WIDTH-1] ^ bus.req_in2[WIDTH-1]);
      rneg   <= sgn && bus.req_in1[WIDTH-1];
      is_rem <= fn_rem(bus.req_fn);
      if (div0)     res <= fn_rem(bus.req_fn) ? bus.req_in1 : '1;
      else if (ovf) res <= fn_rem(bus.req_fn) ? '0 : bus.req_in1;
    end else if (state == CALC && !flush) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt - CW'(1);
      if (last) res <= is_rem ? (rneg ? -rem_n : rem_n) : (qneg ? -quo_n : quo_n);
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  div_if #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return fn[1] ? a : 32'hFFFFFFFF;
    if (!fn[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return fn[1] ? 32'd0 : a;
    case (fn)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0 || (!fn[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
  endfunction

  task automatic issue(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_fn    = div_func_t'(fn);
    bus.req_in1   = a;
    bus.req_in2   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_fn    = div_func_t'($urandom_range(0, 3));
    bus.req_in1   = $urandom;
    bus.req_in2   = $urandom;
  endtask

  task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got, output int lat);
    issue(fn, a, b);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = bus.resp_out;
  endtask

  task automatic take();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_fn     = DIV;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_out !== 32'd0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0", bus.req_ready, bus.resp_valid, bus.resp_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  fn [11] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [31:0] a  [11] = '{20, 20, 20, 20, 32'hFFFFFFEC, 32'hFFFFFFEC, 20, 7, 7, 32'h80000000, 32'h80000000};
    logic [31:0] b  [11] = '{3, 3, 3, 3, 3, 3, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [11] = '{6, 2, 6, 2, 32'hFFFFFFFA, 32'hFFFFFFFE, 2, 32'hFFFFFFFF, 7, 32'h80000000, 0};
    int          el [11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] got;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_ready got %b want 1", i, bus.req_ready);
      end
      run_op(fn[i], a[i], b[i], got, lat);
      checks++;
      if (got !== ex[i] || lat !== el[i]) begin
        errors++;
        $display("FAIL directed%0d got %h lat %0d want %h lat %0d", i, got, lat, ex[i], el[i]);
      end
      take();
    end
  endtask

  task automatic test_grid();
    logic [31:0] got, exp;
    int          lat;
    for (int f = 0; f < 4; f++)
      for (int x = 0; x < 10; x++)
        for (int y = 0; y < 10; y++) begin
          run_op(2'(f), 32'(x), 32'(y), got, lat);
          exp = model(2'(f), 32'(x), 32'(y));
          checks++;
          if (got !== exp || lat !== model_lat(2'(f), 32'(x), 32'(y))) begin
            errors++;
            $display("FAIL grid fn%0d %0d,%0d got %h lat %0d want %h lat %0d", f, x, y, got, lat, exp,
                     model_lat(2'(f), 32'(x), 32'(y)));
          end
          take();
        end
  endtask

  task automatic test_random();
    logic [31:0] a, b, got, exp;
    logic [1:0]  fn;
    int          lat, ka, kb;
    for (int i = 0; i < 80; i++) begin
      fn = 2'($urandom_range(0, 3));
      ka = $urandom_range(0, 3);
      kb = $urandom_range(0, 4);
      a  = ka == 0 ? 32'($urandom_range(0, 1000)) : ka == 1 ? $urandom : ka == 2 ? 32'h80000000 :
           -32'($urandom_range(1, 1000));
      b  = kb == 0 ? 32'd0 : kb == 1 ? 32'hFFFFFFFF : kb == 2 ? 32'($urandom_range(1, 20)) :
           kb == 3 ? $urandom : -32'($urandom_range(1, 20));
      run_op(fn, a, b, got, lat);
      exp = model(fn, a, b);
      checks++;
      if (got !== exp || lat !== model_lat(fn, a, b)) begin
        errors++;
        $display("FAIL random fn%0d %h,%h got %h lat %0d want %h lat %0d", fn, a, b, got, lat, exp, model_lat(fn, a, b));
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          lat;
    run_op(2'd0, 32'd1000, 32'd7, held, lat);
    checks++;
    if (held !== 32'd142) begin
      errors++;
      $display("FAIL bp_value got %h want %h", held, 32'd142);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_out !== 32'd142) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b out=%h want vld=1 rdy=0 out=%h", i, bus.resp_valid,
                 bus.req_ready, bus.resp_out, 32'd142);
      end
    end
    take();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    int          lat;
    issue(2'd0, 32'd500, 32'd3);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL calc_busy got rdy=%b vld=%b want rdy=0 vld=0", bus.req_ready, bus.resp_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_calc got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0", bus.req_ready, bus.resp_valid, bus.resp_out);
    end
    run_op(2'd1, 32'd50, 32'd5, got, lat);
    take();
    issue(2'd0, 32'd500, 32'd3);
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_out !== 32'd10) begin
      errors++;
      $display("FAIL flush_calc got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=%h", bus.req_ready, bus.resp_valid,
               bus.resp_out, 32'd10);
    end
    run_op(2'd3, 32'd50, 32'd7, got, lat);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_out !== 32'd1) begin
      errors++;
      $display("FAIL flush_done got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=1", bus.req_ready, bus.resp_valid, bus.resp_out);
    end
    flush = 1'b1;
    issue(2'd1, 32'd9, 32'd0);
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_req got rdy=%b vld=%b want rdy=1 vld=0", bus.req_ready, bus.resp_valid);
    end
    run_op(2'd0, 32'd100, 32'd7, got, lat);
    checks++;
    if (got !== 32'd14 || lat !== 33) begin
      errors++;
      $display("FAIL after_abort got %h lat %0d want %h lat 33", got, lat, 32'd14);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_grid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
